// File: rtl/encoder_speed_estimator.sv
// encoder_speed_estimator
// Turns the biased per-window edge sum from the quadrature encoder stage into
// a saturated signed delta, a wrapping 32-bit position and a moving-average
// speed offered over a valid/ready handshake.
// Optional feature macro: ENC_DIR_INVERT_EN (mirrored motor mount, negates raw).
module encoder_speed_estimator #(
    parameter int BIAS     = 4192,
    parameter int DELTA_W  = 16,
    parameter int LOG2_AVG = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        count,
    input  logic               count_valid,
    input  logic               pos_clear,
    output logic [DELTA_W-1:0] delta,
    output logic [31:0]        position,
    output logic [DELTA_W-1:0] speed,
    output logic               speed_valid,
    input  logic               speed_ready,
    output logic               overrun
);

    localparam int DEPTH = 1 << LOG2_AVG;
    localparam int SUM_W = DELTA_W + LOG2_AVG;
    localparam int WP_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic signed [31:0] SAT_MAX = 32'sd2 ** (DELTA_W - 1) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd2 ** (DELTA_W - 1));

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        PUBLISH
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [31:0]         raw;
    logic signed [31:0]         raw_dir;
    logic signed [DELTA_W-1:0]  sat;
    logic signed [DELTA_W-1:0]  hist [DEPTH];
    logic signed [SUM_W-1:0]    sum;
    logic signed [SUM_W-1:0]    sum_next;
    logic signed [DELTA_W-1:0]  speed_avg;
    logic [WP_W-1:0]            wp;

    // Direction handling: a mirrored mount flips the sign before saturation
`ifdef ENC_DIR_INVERT_EN
    always_comb raw_dir = -raw;
`else
    always_comb raw_dir = raw;
`endif

    // Clamp the window delta into the signed DELTA_W range
    always_comb begin
        sat = raw_dir[DELTA_W-1:0];
        if (raw_dir > SAT_MAX) begin
            sat = SAT_MAX[DELTA_W-1:0];
        end else if (raw_dir < SAT_MIN) begin
            sat = SAT_MIN[DELTA_W-1:0];
        end
    end

    // Running sum swaps the oldest history entry for the new delta; the
    // average is an arithmetic shift so it rounds toward minus infinity
    always_comb begin
        sum_next  = sum - SUM_W'(hist[wp]) + SUM_W'(sat);
        speed_avg = DELTA_W'(sum >>> LOG2_AVG);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one sample walks IDLE -> ACCUM -> PUBLISH; clear aborts it
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count_valid) state_next = ACCUM;
            ACCUM:   state_next = PUBLISH;
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (pos_clear) begin
            state_next = IDLE;
        end
    end

    // Datapath: latch raw, accumulate, publish speed and run the handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw         <= '0;
            delta       <= '0;
            position    <= '0;
            sum         <= '0;
            wp          <= '0;
            speed       <= '0;
            speed_valid <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        end else if (pos_clear) begin
            delta       <= '0;
            position    <= '0;
            sum         <= '0;
            wp          <= '0;
            speed       <= '0;
            speed_valid <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        end else begin
            if (state == IDLE && count_valid) begin
                raw <= count - 32'(BIAS);
            end
            if (state == ACCUM) begin
                delta    <= sat;
                position <= position + 32'(sat);
                sum      <= sum_next;
                hist[wp] <= sat;
                if (wp == WP_W'(DEPTH - 1)) begin
                    wp <= '0;
                end else begin
                    wp <= wp + 1'b1;
                end
            end
            if (state == PUBLISH) begin
                speed       <= speed_avg;
                speed_valid <= 1'b1;
                if (speed_valid && !speed_ready) begin
                    overrun <= 1'b1;
                end
            end else if (speed_valid && speed_ready) begin
                speed_valid <= 1'b0;
            end
        end
    end

endmodule
